// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - memory, loader, branch and decode signals of the fetch controller
interface instr_fetch_ctrl_if #(
   parameter int WORD_LEN = 16,
   parameter int CELL_W   = 4,
   parameter int ADDR_W   = 8
);
   logic [ADDR_W-1:0]   mem_addr;
   logic [CELL_W-1:0]   mem_rdata;
   logic                mem_we;
   logic [CELL_W-1:0]   mem_wdata;
   logic                ld_req;
   logic [ADDR_W-1:0]   ld_addr;
   logic [CELL_W-1:0]   ld_wdata;
   logic                ld_grant;
   logic                br_taken;
   logic [ADDR_W-1:0]   br_addr;
   logic                id_ready;
   logic [WORD_LEN-1:0] instr;
   logic [ADDR_W-1:0]   instr_pc;
   logic                instr_valid;

   modport master (
      output mem_addr, mem_we, mem_wdata, ld_grant, instr, instr_pc, instr_valid,
      input  mem_rdata, ld_req, ld_addr, ld_wdata, br_taken, br_addr, id_ready
   );

   modport slave (
      input  mem_addr, mem_we, mem_wdata, ld_grant, instr, instr_pc, instr_valid,
      output mem_rdata, ld_req, ld_addr, ld_wdata, br_taken, br_addr, id_ready
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - assembles instructions from narrow memory cells, with branch and loader takeover
module instr_fetch_ctrl #(
   parameter int WORD_LEN = 16,
   parameter int CELL_W   = 4,
   parameter int ADDR_W   = 8
) (
   input logic clk,
   input logic rst,
   instr_fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {FETCH, HOLD, LOAD} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [WORD_LEN-1:0] instr_q, instr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= '0;
         cnt_q   <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
      end
   end

   // Loader beats branch beats normal fetch/handoff in every state.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      instr_d       = instr_q;
      bus.mem_addr  = pc_q;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      bus.ld_grant  = 1'b0;
      case (state_q)
         FETCH: begin
            bus.mem_addr = pc_q + ADDR_W'(cnt_q);
            if (bus.ld_req) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (bus.br_taken) begin
               pc_d  = bus.br_addr;
               cnt_d = '0;
            end else begin
               // First cell lands in the most significant slot.
               instr_d[WORD_LEN-1-CELL_W*int'(cnt_q) -: CELL_W] = bus.mem_rdata;
               if (cnt_q == 2'd3) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         HOLD: begin
            if (bus.ld_req) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (bus.br_taken) begin
               state_d = FETCH;
               pc_d    = bus.br_addr;
               cnt_d   = '0;
            end else if (bus.id_ready) begin
               state_d = FETCH;
               pc_d    = pc_q + ADDR_W'(4);
               cnt_d   = '0;
            end
         end
         LOAD: begin
            bus.ld_grant  = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
            bus.mem_we    = bus.ld_req;
            if (bus.br_taken) pc_d = bus.br_addr;
            if (!bus.ld_req) begin
               state_d = FETCH;
               cnt_d   = '0;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.instr       = instr_q;
   assign bus.instr_pc    = pc_q;
   assign bus.instr_valid = (state_q == HOLD);
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed bench for instr_fetch_ctrl with a cell memory model
module tb_instr_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic init_mem = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [3:0] mem [256];

   always #5 clk = ~clk;

   instr_fetch_ctrl_if bus ();
   instr_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [3:0] preset(int a);
      case (a)
         8'h00: preset = 4'h3;  8'h01: preset = 4'h1;  8'h02: preset = 4'h0;  8'h03: preset = 4'hA;
         8'h04: preset = 4'h5;  8'h05: preset = 4'h6;  8'h06: preset = 4'h7;  8'h07: preset = 4'h8;
         8'h20: preset = 4'h9;  8'h21: preset = 4'hB;  8'h22: preset = 4'hD;  8'h23: preset = 4'hE;
         8'hFC: preset = 4'hC;  8'hFD: preset = 4'h3;  8'hFE: preset = 4'h1;  8'hFF: preset = 4'h1;
         default: preset = 4'h0;
      endcase
   endfunction

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= preset(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk_hold(input string tag, input logic [15:0] ins, input logic [7:0] pc);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
      chk({tag, "_instr"}, 32'(bus.instr), 32'(ins));
      chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(pc));
   endtask

   initial begin
      bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
      bus.br_taken = 1'b0; bus.br_addr = '0; bus.id_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_grant", 32'(bus.ld_grant), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      @(posedge clk); @(negedge clk);
      init_mem = 1'b0;
      rst = 1'b1;

      // first fetch: valid in 4th cycle after release
      tick(3);
      chk("lat3_valid", 32'(bus.instr_valid), 32'd0);
      tick(1);
      chk_hold("first", 16'h310A, 8'h00);

      // stall in HOLD for 10 cycles
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk_hold("stall", 16'h310A, 8'h00);
         chk("stall_addr", 32'(bus.mem_addr), 32'h00);
      end
      bus.id_ready = 1'b1; tick(1); bus.id_ready = 1'b0;
      chk("acc_valid", 32'(bus.instr_valid), 32'd0);
      chk("acc_addr", 32'(bus.mem_addr), 32'h04);
      tick(4);
      chk_hold("second", 16'h5678, 8'h04);

      // branch at cnt=2
      bus.id_ready = 1'b1; tick(1); bus.id_ready = 1'b0;
      tick(2);
      chk("cnt2_addr", 32'(bus.mem_addr), 32'h0A);
      bus.br_taken = 1'b1; bus.br_addr = 8'h20; tick(1); bus.br_taken = 1'b0;
      chk("br_addr", 32'(bus.mem_addr), 32'h20);
      chk("br_valid", 32'(bus.instr_valid), 32'd0);
      tick(3);
      chk("br3_valid", 32'(bus.instr_valid), 32'd0);
      tick(1);
      chk_hold("br", 16'h9BDE, 8'h20);

      // branch and id_ready together: branch wins; wrap fetch at FC
      bus.br_taken = 1'b1; bus.br_addr = 8'hFC; bus.id_ready = 1'b1; tick(1);
      bus.br_taken = 1'b0; bus.id_ready = 1'b0;
      chk("brwin_addr", 32'(bus.mem_addr), 32'hFC);
      chk("brwin_valid", 32'(bus.instr_valid), 32'd0);
      tick(4);
      chk_hold("wrap", 16'hC311, 8'hFC);
      bus.id_ready = 1'b1; tick(1); bus.id_ready = 1'b0;
      chk("wrap_addr", 32'(bus.mem_addr), 32'h00);
      tick(4);
      chk_hold("wrap_next", 16'h310A, 8'h00);

      // loader takeover from HOLD
      bus.ld_req = 1'b1; bus.ld_addr = 8'h10; bus.ld_wdata = 4'hC; bus.id_ready = 1'b1; tick(1);
      bus.id_ready = 1'b0;
      chk("ld_grant", 32'(bus.ld_grant), 32'd1);
      chk("ld_we", 32'(bus.mem_we), 32'd1);
      chk("ld_addr", 32'(bus.mem_addr), 32'h10);
      chk("ld_wdata", 32'(bus.mem_wdata), 32'hC);
      chk("ld_valid", 32'(bus.instr_valid), 32'd0);
      tick(1);
      chk("ld_cell", 32'(mem[8'h10]), 32'hC);
      chk("ld_grant2", 32'(bus.ld_grant), 32'd1);
      bus.ld_req = 1'b0; tick(1);
      chk("ldend_grant", 32'(bus.ld_grant), 32'd0);
      chk("ldend_we", 32'(bus.mem_we), 32'd0);
      chk("ldend_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("ldend_addr", 32'(bus.mem_addr), 32'h00);
      tick(4);
      chk_hold("refetch", 16'h310A, 8'h00);

      // branch during LOAD updates pc but stays in LOAD
      bus.ld_req = 1'b1; tick(1);
      bus.br_taken = 1'b1; bus.br_addr = 8'h04; tick(1); bus.br_taken = 1'b0;
      chk("ldbr_grant", 32'(bus.ld_grant), 32'd1);
      chk("ldbr_pc", 32'(bus.instr_pc), 32'h04);
      bus.ld_req = 1'b0; tick(1);
      chk("ldbr_addr", 32'(bus.mem_addr), 32'h04);
      tick(2);
      chk("ldbr_cnt2", 32'(bus.mem_addr), 32'h06);

      // async reset mid-assembly
      #2 rst = 1'b0; #1;
      chk("arst_addr", 32'(bus.mem_addr), 32'h00);
      chk("arst_instr", 32'(bus.instr), 32'h0);
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      @(negedge clk); rst = 1'b1;
      tick(4);
      chk_hold("arst_restart", 16'h310A, 8'h00);

      // async reset during LOAD
      bus.ld_req = 1'b1; tick(1);
      chk("lrst_pre_grant", 32'(bus.ld_grant), 32'd1);
      #2 rst = 1'b0; #1;
      chk("lrst_grant", 32'(bus.ld_grant), 32'd0);
      chk("lrst_we", 32'(bus.mem_we), 32'd0);
      chk("lrst_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("lrst_addr", 32'(bus.mem_addr), 32'h00);
      bus.ld_req = 1'b0;
      @(negedge clk); rst = 1'b1;
      tick(3);
      chk("lrst3_valid", 32'(bus.instr_valid), 32'd0);
      tick(1);
      chk_hold("lrst_restart", 16'h310A, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
